// File: rtl/udi_pow_detect_pkg.sv
// udi_pow_pkg: shared types and constants for the UDI power detector.
//   POW_W       : width of power samples, averages and threshold
//   pow_state_e : confirm/release state encoding (00/01/10/11)
package udi_pow_pkg;

   localparam int POW_W = 32;

   typedef enum logic [1:0] {
      SEARCH  = 2'b00,
      CONFIRM = 2'b01,
      DETECT  = 2'b10,
      RELEASE = 2'b11
   } pow_state_e;

endpackage

// File: rtl/udi_pow_detect_if.sv
// udi_pow_detect_if: sample stream in, window result and detection out.
//   in_valid/in_pow                : power sample from the UDI power instruction
//   avg_valid/avg_pow              : window-average update pulse and value
//   det/det_rise/det_fall          : detection level and edge pulses
//   master : sample producer / status consumer
//   slave  : the detector
interface udi_pow_detect_if;

   logic                          in_valid;
   logic [udi_pow_pkg::POW_W-1:0] in_pow;
   logic                          avg_valid;
   logic [udi_pow_pkg::POW_W-1:0] avg_pow;
   logic                          det;
   logic                          det_rise;
   logic                          det_fall;

   modport master (
      output in_valid, in_pow,
      input  avg_valid, avg_pow, det, det_rise, det_fall
   );

   modport slave (
      input  in_valid, in_pow,
      output avg_valid, avg_pow, det, det_rise, det_fall
   );

endinterface

// File: rtl/udi_pow_detect_win_acc.sv
// udi_pow_win_acc: block accumulator over 2^WIN_LOG2 valid samples.
//   clk_i, rst_i   : clock, synchronous active-high reset (greset | clr)
//   in_valid_i/in_pow_i : sample stream
//   close_o        : combinational, high on the edge that closes a window
//   avg_next_o     : combinational average including the current sample
//   avg_valid_o    : registered one-cycle pulse after window close
//   avg_pow_o      : registered last window average
module udi_pow_win_acc
   import udi_pow_pkg::*;
#(
   parameter int WIN_LOG2 = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   input  logic [POW_W-1:0] in_pow_i,
   output logic             close_o,
   output logic [POW_W-1:0] avg_next_o,
   output logic             avg_valid_o,
   output logic [POW_W-1:0] avg_pow_o
);

   localparam int ACC_W = POW_W + WIN_LOG2;

   logic [ACC_W-1:0]    acc_q;
   logic [ACC_W-1:0]    sum_d;
   logic [WIN_LOG2-1:0] cnt_q;
   logic                avg_valid_q;
   logic [POW_W-1:0]    avg_pow_q;

   // Accumulator carries WIN_LOG2 guard bits, so the full window sum fits.
   assign sum_d      = acc_q + ACC_W'(in_pow_i);
   assign close_o    = in_valid_i && (cnt_q == '1);
   assign avg_next_o = sum_d[ACC_W-1:WIN_LOG2];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         avg_valid_q <= 1'b0;
         avg_pow_q   <= '0;
      end else begin
         avg_valid_q <= 1'b0;
         if (in_valid_i) begin
            if (close_o) begin
               acc_q       <= '0;
               cnt_q       <= '0;
               avg_pow_q   <= avg_next_o;
               avg_valid_q <= 1'b1;
            end else begin
               acc_q <= sum_d;
               cnt_q <= cnt_q + WIN_LOG2'(1);
            end
         end
      end
   end

   assign avg_valid_o = avg_valid_q;
   assign avg_pow_o   = avg_pow_q;

endmodule

// File: rtl/udi_pow_detect.sv
// udi_pow_detect: windowed power average with hit/miss confirm hysteresis.
//   gclk, greset   : clock, synchronous active-high reset
//   pif (slave)    : sample stream in, average and detection status out
//   cfg_thr        : strict-greater threshold on the window average
//   cfg_hits       : consecutive hit windows to assert det (0 acts as 1)
//   cfg_miss       : consecutive miss windows to release det (0 acts as 1)
//   clr            : synchronous soft clear, same effect as greset
// Optional build macro UDI_POW_DET_PEAK_EN adds:
//   peak_clr       : clears the peak register only
//   peak_pow       : maximum window average since reset/clr/peak_clr
//
// state   | meaning
// SEARCH  | det=0, waiting for a first hit window
// CONFIRM | det=0, counting consecutive hit windows
// DETECT  | det=1, steady detection
// RELEASE | det=1, counting consecutive miss windows
module udi_pow_detect
   import udi_pow_pkg::*;
#(
   parameter int WIN_LOG2 = 4,
   parameter int CNT_W    = 4
) (
   input  logic              gclk,
   input  logic              greset,
   udi_pow_detect_if.slave   pif,
   input  logic [POW_W-1:0]  cfg_thr,
   input  logic [CNT_W-1:0]  cfg_hits,
   input  logic [CNT_W-1:0]  cfg_miss,
   input  logic              clr
`ifdef UDI_POW_DET_PEAK_EN
   ,
   input  logic              peak_clr,
   output logic [POW_W-1:0]  peak_pow
`endif
);

   logic             rst;
   logic             close;
   logic [POW_W-1:0] avg_next;
   logic             hit;
   logic [CNT_W-1:0] eff_hits;
   logic [CNT_W-1:0] eff_miss;
   logic [CNT_W-1:0] hit_inc;
   logic [CNT_W-1:0] miss_inc;

   pow_state_e       state_q;
   logic [CNT_W-1:0] hit_cnt_q;
   logic [CNT_W-1:0] miss_cnt_q;
   logic             det_q;
   logic             det_rise_q;
   logic             det_fall_q;

   assign rst = greset | clr;

   udi_pow_win_acc #(
      .WIN_LOG2 (WIN_LOG2)
   ) u_win_acc (
      .clk_i       (gclk),
      .rst_i       (rst),
      .in_valid_i  (pif.in_valid),
      .in_pow_i    (pif.in_pow),
      .close_o     (close),
      .avg_next_o  (avg_next),
      .avg_valid_o (pif.avg_valid),
      .avg_pow_o   (pif.avg_pow)
   );

   // Decision uses the average being registered on this same edge, so the
   // det change lines up with avg_valid.
   assign hit      = avg_next > cfg_thr;
   assign eff_hits = (cfg_hits == '0) ? CNT_W'(1) : cfg_hits;
   assign eff_miss = (cfg_miss == '0) ? CNT_W'(1) : cfg_miss;
   assign hit_inc  = (hit_cnt_q  == '1) ? hit_cnt_q  : hit_cnt_q  + CNT_W'(1);
   assign miss_inc = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);

   // Terminal compares use >= so a config lowered mid-count still resolves.
   always_ff @(posedge gclk) begin
      if (rst) begin
         state_q    <= SEARCH;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         det_q      <= 1'b0;
         det_rise_q <= 1'b0;
         det_fall_q <= 1'b0;
      end else begin
         det_rise_q <= 1'b0;
         det_fall_q <= 1'b0;
         if (close) begin
            unique case (state_q)
               SEARCH: begin
                  if (hit) begin
                     hit_cnt_q <= CNT_W'(1);
                     if (eff_hits == CNT_W'(1)) begin
                        state_q    <= DETECT;
                        det_q      <= 1'b1;
                        det_rise_q <= 1'b1;
                     end else begin
                        state_q <= CONFIRM;
                     end
                  end else begin
                     hit_cnt_q <= '0;
                  end
               end
               CONFIRM: begin
                  if (hit) begin
                     hit_cnt_q <= hit_inc;
                     if (hit_inc >= eff_hits) begin
                        state_q    <= DETECT;
                        det_q      <= 1'b1;
                        det_rise_q <= 1'b1;
                     end
                  end else begin
                     hit_cnt_q <= '0;
                     state_q   <= SEARCH;
                  end
               end
               DETECT: begin
                  if (!hit) begin
                     miss_cnt_q <= CNT_W'(1);
                     if (eff_miss == CNT_W'(1)) begin
                        state_q    <= SEARCH;
                        det_q      <= 1'b0;
                        det_fall_q <= 1'b1;
                     end else begin
                        state_q <= RELEASE;
                     end
                  end else begin
                     miss_cnt_q <= '0;
                  end
               end
               RELEASE: begin
                  if (!hit) begin
                     miss_cnt_q <= miss_inc;
                     if (miss_inc >= eff_miss) begin
                        state_q    <= SEARCH;
                        det_q      <= 1'b0;
                        det_fall_q <= 1'b1;
                     end
                  end else begin
                     miss_cnt_q <= '0;
                     state_q    <= DETECT;
                  end
               end
               default: state_q <= SEARCH;
            endcase
         end
      end
   end

   assign pif.det      = det_q;
   assign pif.det_rise = det_rise_q;
   assign pif.det_fall = det_fall_q;

`ifdef UDI_POW_DET_PEAK_EN
   logic [POW_W-1:0] peak_q;

   // A fresh average beats peak_clr: the clear restarts tracking from it.
   always_ff @(posedge gclk) begin
      if (rst) begin
         peak_q <= '0;
      end else if (close && (peak_clr || (avg_next > peak_q))) begin
         peak_q <= avg_next;
      end else if (peak_clr) begin
         peak_q <= '0;
      end
   end

   assign peak_pow = peak_q;
`endif

endmodule

// File: tb/tb_udi_pow_detect.sv
module tb_udi_pow_detect;
   import udi_pow_pkg::*;

   logic        gclk = 1'b0;
   logic        greset;
   logic        clr;
   logic [31:0] cfg_thr;
   logic [3:0]  cfg_hits;
   logic [3:0]  cfg_miss;
`ifdef UDI_POW_DET_PEAK_EN
   logic        peak_clr;
   logic [31:0] peak_pow;
`endif

   udi_pow_detect_if pif ();

   udi_pow_detect #(
      .WIN_LOG2 (4),
      .CNT_W    (4)
   ) dut (
      .gclk     (gclk),
      .greset   (greset),
      .pif      (pif.slave),
      .cfg_thr  (cfg_thr),
      .cfg_hits (cfg_hits),
      .cfg_miss (cfg_miss),
      .clr      (clr)
`ifdef UDI_POW_DET_PEAK_EN
      ,
      .peak_clr (peak_clr),
      .peak_pow (peak_pow)
`endif
   );

   always #5 gclk = ~gclk;

   int cyc = 0;
   always @(posedge gclk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] avg;
      logic        det;
      logic        rise;
      logic        fall;
      int          cyc;
      int          id;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   passes = 0;
   int   win_id = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Monitor: every avg_valid pops one expected window result.
   exp_t e;
   always @(negedge gclk) begin
      if (pif.avg_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_avg_valid: got avg_valid=1 expected 0 at cycle %0d", cyc);
         end else begin
            e = sbq.pop_front();
            chk($sformatf("w%0d_avg", e.id),  pif.avg_pow, e.avg);
            chk($sformatf("w%0d_det", e.id),  32'(pif.det), 32'(e.det));
            chk($sformatf("w%0d_rise", e.id), 32'(pif.det_rise), 32'(e.rise));
            chk($sformatf("w%0d_fall", e.id), 32'(pif.det_fall), 32'(e.fall));
            chk($sformatf("w%0d_latency_cycle", e.id), 32'(cyc), 32'(e.cyc));
         end
      end else if (pif.det_rise === 1'b1 || pif.det_fall === 1'b1) begin
         checks++;
         $display("FAIL stray_edge_pulse: got rise=%b fall=%b expected 0 0 at cycle %0d",
                  pif.det_rise, pif.det_fall, cyc);
      end
   end

   // 16 samples base+i*step; expected result pushed right after the closing edge.
   task automatic window(input logic [31:0] base, input logic [31:0] step,
                         input logic [31:0] avg, input logic d, input logic r,
                         input logic f, input int gap);
      exp_t x;
      for (int i = 0; i < 16; i++) begin
         pif.in_valid = 1'b1;
         pif.in_pow   = base + step * 32'(i);
         @(posedge gclk);
         #1;
         pif.in_valid = 1'b0;
         if (i == 15) begin
            x.avg  = avg;
            x.det  = d;
            x.rise = r;
            x.fall = f;
            x.cyc  = cyc;
            x.id   = win_id;
            win_id++;
            sbq.push_back(x);
         end
         repeat (gap) begin
            @(posedge gclk);
            #1;
         end
      end
   endtask

   task automatic partial(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         pif.in_valid = 1'b1;
         pif.in_pow   = v;
         @(posedge gclk);
         #1;
      end
      pif.in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, expected finish before 100000ns");
      $fatal(1);
   end

   initial begin
      greset       = 1'b1;
      clr          = 1'b0;
      pif.in_valid = 1'b0;
      pif.in_pow   = '0;
      cfg_thr      = 32'd1000;
      cfg_hits     = 4'd1;
      cfg_miss     = 4'd1;
`ifdef UDI_POW_DET_PEAK_EN
      peak_clr     = 1'b0;
`endif
      repeat (3) @(posedge gclk);
      #1;
      greset = 1'b0;
      chk("rst_avg_valid", 32'(pif.avg_valid), 32'd0);
      chk("rst_avg_pow",   pif.avg_pow,        32'd0);
      chk("rst_det",       32'(pif.det),       32'd0);
      chk("rst_det_rise",  32'(pif.det_rise),  32'd0);
      chk("rst_det_fall",  32'(pif.det_fall),  32'd0);

      // Plain average, full-scale without overflow, strict threshold, truncation.
      window(32'd100, 32'd0, 32'd100, 1'b0, 1'b0, 1'b0, 0);
      cfg_thr = 32'hFFFF_FFFF;
      window(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
      window(32'd0, 32'd1, 32'd7, 1'b0, 1'b0, 1'b0, 0);

      // Confirm with 3 hits; the 40 window restarts the count.
      cfg_thr  = 32'd50;
      cfg_hits = 4'd3;
      window(32'd60, 32'd0, 32'd60, 1'b0, 1'b0, 1'b0, 0);
      window(32'd60, 32'd0, 32'd60, 1'b0, 1'b0, 1'b0, 0);
      window(32'd40, 32'd0, 32'd40, 1'b0, 1'b0, 1'b0, 0);
      window(32'd60, 32'd0, 32'd60, 1'b0, 1'b0, 1'b0, 0);
      window(32'd60, 32'd0, 32'd60, 1'b0, 1'b0, 1'b0, 0);
      window(32'd60, 32'd0, 32'd60, 1'b1, 1'b1, 1'b0, 0);

      // Release with 2 misses; the 70 window restarts the count.
      cfg_miss = 4'd2;
      window(32'd10, 32'd0, 32'd10, 1'b1, 1'b0, 1'b0, 0);
      window(32'd70, 32'd0, 32'd70, 1'b1, 1'b0, 1'b0, 0);
      window(32'd10, 32'd0, 32'd10, 1'b1, 1'b0, 1'b0, 0);
      window(32'd10, 32'd0, 32'd10, 1'b0, 1'b0, 1'b1, 0);

      // Gapped input (1 in 3), then greset mid-window discards the partial sum.
      window(32'd100, 32'd0, 32'd100, 1'b0, 1'b0, 1'b0, 2);
      partial(32'd1000, 7);
      greset = 1'b1;
      @(posedge gclk);
      #1;
      greset = 1'b0;
      chk("greset_avg_pow", pif.avg_pow, 32'd0);
      window(32'd8, 32'd0, 32'd8, 1'b0, 1'b0, 1'b0, 0);

      // cfg_hits=0 acts as 1.
      cfg_hits = 4'd0;
      window(32'd60, 32'd0, 32'd60, 1'b1, 1'b1, 1'b0, 0);

      // clr from DETECT mid-window, coincident sample dropped.
      partial(32'd1000, 5);
      pif.in_valid = 1'b1;
      pif.in_pow   = 32'd1000;
      clr          = 1'b1;
      @(posedge gclk);
      #1;
      clr          = 1'b0;
      pif.in_valid = 1'b0;
      chk("clr_det",     32'(pif.det), 32'd0);
      chk("clr_avg_pow", pif.avg_pow,  32'd0);
      window(32'd20, 32'd0, 32'd20, 1'b0, 1'b0, 1'b0, 0);

      // cfg_miss=0 acts as 1.
      cfg_miss = 4'd0;
      window(32'd60, 32'd0, 32'd60, 1'b1, 1'b1, 1'b0, 0);
      window(32'd10, 32'd0, 32'd10, 1'b0, 1'b0, 1'b1, 0);

`ifdef UDI_POW_DET_PEAK_EN
      chk("peak_since_clr", peak_pow, 32'd60);
`endif

      repeat (4) @(posedge gclk);
      #1;
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/udi_pow_detect.md
Name: udi_pow_detect

Overview:
- Downstream consumer of the UDI power instruction's per-sample power word (I²+Q² or sum/sum-shift result).
- Block-averages power over a 2^WIN_LOG2-sample window and compares each window average against a programmable threshold.
- Runs a confirm/release state machine, so detection asserts only after CFG-many consecutive hit windows and drops only after CFG-many consecutive miss windows.
- Output feeds UDI status reads and the core's interrupt/event logic.

Parameters:
- WIN_LOG2, 4: log2 of window length in samples; legal 1..8.
- CNT_W, 4: width of the hit/miss confirm counters and the cfg_hits/cfg_miss ports.

Ports:
- gclk  in  1  core clock; all state changes on rising edge.
- greset  in  1  synchronous, active-high reset.
- in_valid  in  1  one power sample presented this cycle.
- in_pow  in  32  unsigned power sample.
- cfg_thr  in  32  unsigned detection threshold; sampled at each window close.
- cfg_hits  in  CNT_W  consecutive hit windows needed to assert det; 0 is treated as 1.
- cfg_miss  in  CNT_W  consecutive miss windows needed to release det; 0 is treated as 1.
- clr  in  1  synchronous soft clear; same effect as greset except config inputs are not registered here anyway.
- avg_valid  out  1  one-cycle pulse: avg_pow updated.
- avg_pow  out  32  last window average, (sum >> WIN_LOG2), truncated.
- det  out  1  detection state.
- det_rise  out  1  one-cycle pulse on the 0->1 transition of det.
- det_fall  out  1  one-cycle pulse on the 1->0 transition of det.

Behaviour:
- Reset (greset or clr): accumulator=0, sample count=0, hit/miss counters=0, state=SEARCH. avg_valid=0, avg_pow=0, det=0, det_rise=0, det_fall=0. greset wins over all other inputs; reset mid-window discards partial sums.
- Accumulator is 32+WIN_LOG2 bits wide and cannot overflow. Each in_valid cycle adds in_pow and increments the sample count. in_valid=0 holds all state; gaps are allowed.
- Window close occurs on the in_valid cycle where count == 2^WIN_LOG2-1. On that edge:
  - avg_pow <= (acc+in_pow) >> WIN_LOG2.
  - accumulator <= 0 and count <= 0; the next window starts clean with no dropped sample.
  - avg_valid=1 on the following cycle. Latency is 1 cycle from the last sample.
- hit = (window average > cfg_thr), strict compare. It is evaluated on the same edge from the new average value, so the state update and det change coincide with avg_valid.
- State machine, updated only at window close:
  - SEARCH: hit -> hit_cnt=1. If eff_hits==1, go to DETECT; otherwise go to CONFIRM.
  - CONFIRM: hit -> hit_cnt+1; go to DETECT when it reaches eff_hits. Miss -> hit_cnt=0, back to SEARCH.
  - DETECT: miss -> miss_cnt=1. If eff_miss==1, go to SEARCH; otherwise go to RELEASE. Hit -> stay.
  - RELEASE: miss -> miss_cnt+1; go to SEARCH when it reaches eff_miss. Hit -> miss_cnt=0, back to DETECT.
- det=1 in DETECT and RELEASE. det_rise/det_fall pulse for exactly the avg_valid cycle in which det changes.
- Config changes take effect at the next window close. Counters saturate at 2^CNT_W-1.
- If clr and in_valid occur in the same cycle, clr wins and the sample is dropped.

Optional Feature:
- Macro UDI_POW_DET_PEAK_EN.
- When defined:
  - Adds output peak_pow[31:0], holding the maximum avg_pow seen since reset/clr.
  - Updated on the avg_valid cycle; reset value is 0.
  - Adds input peak_clr, which clears only peak_pow.
  - If peak_clr coincides with an update, the new average is loaded.
- When undefined: neither port exists and no peak logic is present.

Decomposition:
- Shared package udi_pow_pkg holds the state enum (SEARCH/CONFIRM/DETECT/RELEASE, 2-bit encoding 00/01/10/11) and the power/threshold width constant POW_W=32.
- One natural sub-module: udi_pow_win_acc (accumulator, count, window-close pulse, avg_pow register). The FSM and counters stay in the top.

Test Plan:
- WIN_LOG2=4, 16 samples of 100 -> avg_valid one cycle after the 16th sample, avg_pow=100; no avg_valid before that.
- 16 samples of 0xFFFFFFFF -> avg_pow=0xFFFFFFFF (no overflow); cfg_thr=0xFFFFFFFF -> no hit (strict compare).
- cfg_thr=50, cfg_hits=3, window averages 60,60,40,60,60,60 -> det rises with the 6th avg_valid, det_rise pulsed once.
- In DETECT, cfg_miss=2, averages 10,70,10,10 -> det stays 1 through the 3rd window and falls at the 4th with det_fall.
- in_valid gated to 1-in-3 cycles, 16 samples -> same avg_pow as contiguous input; greset after 7 samples, then 16 samples of 8 -> avg_pow=8.
- cfg_hits=0, one window average above thr -> det rises at the first window close (treated as 1).
